uart_tx: RTL and testbench

- UART transmitter: accepts words over a valid/ready write interface and serialises each one onto a single TX line.
- Frame: start bit, WORD_WIDTH data bits LSB first, optional odd parity bit, one stop bit.
- Contains its own baud tick divider, a one-entry holding buffer and a frame FSM.
- Sits beside the UART receiver in the UART peripheral. The frame format matches the receiver, so a tx to rx loopback recovers every word.

---
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready write port, one-entry holding buffer, internal
// baud tick divider and a start/data/odd-parity/stop frame FSM driving dout.
`ifndef SYSFREQ
`define SYSFREQ 50000000
`endif

module uart_tx #(
  parameter int WORD_WIDTH   = 8,
  parameter int OVERSAMPLING = 16,
  parameter int BAUD_RATE    = 115200,
  parameter int FREQ         = `SYSFREQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  parity,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  dout,
  output logic                  busy
);

  localparam int DIV_RAW = FREQ / (BAUD_RATE * OVERSAMPLING);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int IW      = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [DW-1:0]         div_q, div_d;
  logic [TW-1:0]         tcnt_q, tcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  full_q, full_d;
  logic                  par_en_q;
  logic [WORD_WIDTH-1:0] buf_q;
  logic [WORD_WIDTH-1:0] shift_q;
  logic                  par_bit_q;

  logic tick, bit_end, load, clr, accept;

  assign wr_ready = ~full_q;
  assign accept   = wr_valid & ~full_q;
  assign busy     = (state_q != IDLE);
  assign tick     = (div_q == DW'(DIV - 1));
  assign bit_end  = tick & (tcnt_q == TW'(OVERSAMPLING - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    dout    = 1'b1;
    case (state_q)
      IDLE: begin
        if (full_q) load = 1'b1;
      end
      START: begin
        dout = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        dout = shift_q[0];
        if (bit_end) begin
          if (idx_q == IW'(WORD_WIDTH - 1)) state_d = par_en_q ? PARITY : STOP;
          else                              idx_d   = idx_q + IW'(1);
        end
      end
      PARITY: begin
        dout = par_bit_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (full_q) load    = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      state_d = START;
      idx_d   = '0;
    end
  end

  // Only a load out of IDLE realigns the divider; back-to-back frames keep it running.
  assign clr = load & (state_q == IDLE);

  always_comb begin
    div_d  = tick ? '0 : div_q + DW'(1);
    tcnt_d = tcnt_q;
    if (tick) tcnt_d = (tcnt_q == TW'(OVERSAMPLING - 1)) ? '0 : tcnt_q + TW'(1);
    if (clr) begin
      div_d  = '0;
      tcnt_d = '0;
    end
    full_d = full_q;
    if (load)        full_d = 1'b0;
    else if (accept) full_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tcnt_q   <= '0;
      idx_q    <= '0;
      full_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      idx_q   <= idx_d;
      full_q  <= full_d;
      if (load) par_en_q <= parity;
    end
  end

  // Datapath registers carry no reset; they are only observed once loaded.
  always_ff @(posedge clk) begin
    if (accept) buf_q <= wr_data;
    if (load) begin
      shift_q   <= buf_q;
      par_bit_q <= ~^buf_q;
    end else if (state_q == DATA && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at FREQ=16, BAUD_RATE=1, OVERSAMPLING=4 (16 clocks per bit).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       parity = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, dout, busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(
    .WORD_WIDTH  (8),
    .OVERSAMPLING(4),
    .BAUD_RATE   (1),
    .FREQ        (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .parity  (parity),
    .wr_valid(wr_valid),
    .wr_data (wr_data),
    .wr_ready(wr_ready),
    .dout    (dout),
    .busy    (busy)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not end, time=%0t required earlier", $time);
    $fatal(1);
  end

  // Offer d and return at the negedge just after the accepting posedge.
  task automatic put(input logic [7:0] d, output bit to);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (wr_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    to = (n >= 2000);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Entered at cycle `skip` of the start bit; checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] d, input logic par, input int skip, input string nm);
    logic [10:0] bits;
    int n;
    logic bad_d, bad_b, seen;
    bits = {1'b1, ~^d, d, 1'b0};
    n = par ? 11 : 10;
    if (!par) bits[9] = 1'b1;
    for (int b = 0; b < n; b++) begin
      bad_d = 1'b0;
      bad_b = 1'b0;
      seen  = bits[b];
      for (int c = (b == 0) ? skip : 0; c < 16; c++) begin
        if (dout !== bits[b]) begin
          bad_d = 1'b1;
          seen  = dout;
        end
        if (busy !== 1'b1) bad_b = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad_d) begin
        errors++;
        $display("FAIL %s bit%0d: dout=%b expected %b", nm, b, seen, bits[b]);
      end
      checks++;
      if (bad_b) begin
        errors++;
        $display("FAIL %s busy bit%0d: busy dropped, expected 1", nm, b);
      end
    end
  endtask

  // Behavioural receiver: mid-bit sampling from the detected falling edge.
  task automatic rx_frame(input logic par, output logic [7:0] d, output bit perr,
                          output bit ferr, output bit to);
    int n;
    n = 0;
    to = 1'b0; perr = 1'b0; ferr = 1'b0; d = 8'h00;
    while (dout !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      to = 1'b1;
      return;
    end
    repeat (8) @(negedge clk);
    if (dout !== 1'b0) ferr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(negedge clk);
      d[i] = dout;
    end
    if (par) begin
      repeat (16) @(negedge clk);
      if (dout !== ~^d) perr = 1'b1;
    end
    repeat (16) @(negedge clk);
    if (dout !== 1'b1) ferr = 1'b1;
  endtask

  task automatic test_reset();
    logic bad;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dout !== 1'b1)     begin errors++; $display("FAIL reset dout: got %b expected 1", dout); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset wr_ready: got %b expected 1", wr_ready); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    parity   = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h00;
    @(negedge clk);
    wr_data = 8'h81;
    repeat (3) @(negedge clk);
    wr_valid = 1'b0;
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL midreset buffer: wr_ready=%b expected 0", wr_ready); end
    repeat (20) @(negedge clk);
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL midreset pre dout: got %b expected 0", dout); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset pre busy: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (dout !== 1'b1)     begin errors++; $display("FAIL async dout: got %b expected 1", dout); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL async busy: got %b expected 0", busy); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL async wr_ready: got %b expected 1", wr_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dout !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL post reset idle: line/buffer active, expected idle and empty"); end
  endtask

  task automatic test_a5_parity();
    bit to;
    parity = 1'b1;
    put(8'hA5, to);
    checks++; if (to) begin errors++; $display("FAIL a5 handshake: timeout, expected accept"); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL a5 ready drop: got %b expected 0", wr_ready); end
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL a5 latency: dout=%b expected 1 one cycle after handshake", dout); end
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL a5 ready rise: got %b expected 1", wr_ready); end
    check_frame(8'hA5, 1'b1, 0, "a5");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5 busy end: got %b expected 0", busy); end
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL a5 idle line: got %b expected 1", dout); end
  endtask

  task automatic test_no_parity();
    bit to;
    parity = 1'b0;
    put(8'h01, to);
    checks++; if (to) begin errors++; $display("FAIL 01 handshake: timeout, expected accept"); end
    @(negedge clk);
    parity = 1'b1;
    check_frame(8'h01, 1'b0, 0, "w01");
    parity = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL w01 busy end: got %b expected 0 at clock 160", busy); end
    checks++; if (dout !== 1'b1) begin errors++; $display("FAIL w01 idle line: got %b expected 1", dout); end
  endtask

  task automatic test_back_to_back();
    parity   = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'h55;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b ready drop: got %b expected 0", wr_ready); end
    wr_data = 8'hFF;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b ready rise: got %b expected 1", wr_ready); end
    checks++; if (dout !== 1'b0) begin errors++; $display("FAIL b2b start: dout=%b expected 0", dout); end
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b second accept: wr_ready=%b expected 0", wr_ready); end
    wr_valid = 1'b0;
    check_frame(8'h55, 1'b0, 1, "b2b_first");
    check_frame(8'hFF, 1'b0, 0, "b2b_second");
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b busy end: got %b expected 0", busy); end
  endtask

  task automatic test_backpressure();
    int captured, n;
    logic [7:0] got, want;
    bit perr, ferr, to;
    parity = 1'b0;
    exp_q.delete();
    fork
      begin
        captured = 0;
        n = 0;
        wr_valid = 1'b1;
        while (captured < 3 && n < 2000) begin
          wr_data = 8'($urandom);
          if (wr_ready === 1'b1) begin
            exp_q.push_back(wr_data);
            captured++;
          end
          @(negedge clk);
          n++;
        end
        wr_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          rx_frame(1'b0, got, perr, ferr, to);
          want = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
          checks++;
          if (to || ferr || got !== want) begin
            errors++;
            $display("FAIL backpressure word%0d: got %h (to=%b ferr=%b) expected %h", k, got, to, ferr, want);
          end
        end
      end
    join
  endtask

  task automatic test_loopback();
    logic [7:0] got, want, w;
    bit perr, ferr, to, pto;
    parity = 1'b1;
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 256; k++) begin
          w = 8'($urandom);
          exp_q.push_back(w);
          put(w, pto);
        end
      end
      begin
        for (int k = 0; k < 256; k++) begin
          rx_frame(1'b1, got, perr, ferr, to);
          want = (exp_q.size() > 0) ? exp_q.pop_front() : ~got;
          checks++;
          if (to || perr || ferr || got !== want) begin
            errors++;
            $display("FAIL loopback word%0d: got %h (to=%b perr=%b ferr=%b) expected %h", k, got, to, perr, ferr, want);
          end
        end
      end
    join
    parity = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a5_parity();
    test_no_parity();
    test_back_to_back();
    test_backpressure();
    repeat (20) @(negedge clk);
    test_loopback();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
